// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the PC redirect controller: FSM state encoding,
// redirect source/priority codes and the default address width.
package pc_redirect_ctrl_pkg;

    localparam int ADDR_W_DEFAULT = 32;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    // Numeric order of the codes is the priority order.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ID   = 2'd1,
        SRC_EX   = 2'd2,
        SRC_TRAP = 2'd3
    } redir_src_e;

endpackage

// File: rtl/pc_redirect_ctrl_prio_enc.sv
// Combinational priority encoder: trap > ex_branch > id_jump.
module redirect_prio_enc
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              trap_vld,
    input  logic [ADDR_W-1:0] trap_addr,
    input  logic              ex_vld,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic              id_vld,
    input  logic [ADDR_W-1:0] id_addr,
    output redir_src_e        src,
    output logic [ADDR_W-1:0] addr
);

    always_comb begin
        src  = SRC_NONE;
        addr = '0;
        if (trap_vld) begin
            src  = SRC_TRAP;
            addr = trap_addr;
        end else if (ex_vld) begin
            src  = SRC_EX;
            addr = ex_addr;
        end else if (id_vld) begin
            src  = SRC_ID;
            addr = id_addr;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: issues jump/branch/trap redirects to the PC generator,
// parking the highest-priority one in a single pending register while fetch is held.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_ready,
    input  logic              stall_req,
    input  logic              id_jump,
    input  logic [ADDR_W-1:0] id_jump_addr,
    input  logic              ex_branch,
    input  logic [ADDR_W-1:0] ex_branch_addr,
    input  logic              trap_req,
    input  logic [ADDR_W-1:0] trap_vec,
    output logic              trap_ack,
    output logic              pc_hold,
    output logic              pc_branch,
    output logic [ADDR_W-1:0] pc_branch_addr,
    output logic              flush_if,
    output logic              flush_id,
    output logic              pend_valid
);

    logic [0:0]        state_q, state_d;
    redir_src_e        pend_src_q, pend_src_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              ack_hist_q, ack_hist_d;

    redir_src_e        new_src;
    logic [ADDR_W-1:0] new_addr;
    redir_src_e        iss_src;
    logic [ADDR_W-1:0] iss_addr;
    redir_src_e        merge_src;
    logic [ADDR_W-1:0] merge_addr;
    logic              hold;
    logic              trap_eff;

    // A trap that was just acknowledged may still be visible for one cycle.
    assign trap_eff = trap_req & ~ack_hist_q;
    assign hold     = ~imem_ready | stall_req;

    redirect_prio_enc #(.ADDR_W(ADDR_W)) u_prio_enc (
        .trap_vld  (trap_eff),
        .trap_addr (trap_vec),
        .ex_vld    (ex_branch),
        .ex_addr   (ex_branch_addr),
        .id_vld    (id_jump),
        .id_addr   (id_jump_addr),
        .src       (new_src),
        .addr      (new_addr)
    );

    always_comb begin
        state_d     = state_q;
        pend_src_d  = pend_src_q;
        pend_addr_d = pend_addr_q;
        iss_src     = SRC_NONE;
        iss_addr    = '0;
        merge_src   = pend_src_q;
        merge_addr  = pend_addr_q;

        if (new_src > pend_src_q) begin
            merge_src  = new_src;
            merge_addr = new_addr;
        end

        case (state_q)
            ST_RUN: begin
                if (new_src != SRC_NONE) begin
                    if (hold) begin
                        pend_src_d  = new_src;
                        pend_addr_d = new_addr;
                        state_d     = ST_PEND;
                    end else begin
                        iss_src  = new_src;
                        iss_addr = new_addr;
                    end
                end
            end
            ST_PEND: begin
                if (hold) begin
                    pend_src_d  = merge_src;
                    pend_addr_d = merge_addr;
                end else begin
                    iss_src     = merge_src;
                    iss_addr    = merge_addr;
                    pend_src_d  = SRC_NONE;
                    pend_addr_d = '0;
                    state_d     = ST_RUN;
                end
            end
            default: begin
                state_d     = ST_RUN;
                pend_src_d  = SRC_NONE;
                pend_addr_d = '0;
            end
        endcase
    end

    // Outputs are forced quiet while reset is asserted.
    always_comb begin
        pc_hold        = ~rst & hold;
        pc_branch      = ~rst & (iss_src != SRC_NONE);
        pc_branch_addr = pc_branch ? iss_addr : '0;
        flush_if       = pc_branch;
        flush_id       = pc_branch & ((iss_src == SRC_EX) | (iss_src == SRC_TRAP));
        trap_ack       = pc_branch & (iss_src == SRC_TRAP);
        pend_valid     = (state_q == ST_PEND);
        ack_hist_d     = trap_ack;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pend_src_q  <= SRC_NONE;
            pend_addr_q <= '0;
            ack_hist_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_src_q  <= pend_src_d;
            pend_addr_q <= pend_addr_d;
            ack_hist_q  <= ack_hist_d;
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios then random traffic
// compared against a rank-based reference model.
module tb_pc_redirect_ctrl;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_ready, stall_req;
    logic          id_jump, ex_branch, trap_req;
    logic [AW-1:0] id_jump_addr, ex_branch_addr, trap_vec;
    logic          trap_ack, pc_hold, pc_branch, flush_if, flush_id, pend_valid;
    logic [AW-1:0] pc_branch_addr;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model: pending redirect as (valid, rank, addr) plus last-cycle ack
    bit          m_pv;
    int          m_prank;
    logic [AW-1:0] m_paddr;
    bit          m_ack_last;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_ready     (imem_ready),
        .stall_req      (stall_req),
        .id_jump        (id_jump),
        .id_jump_addr   (id_jump_addr),
        .ex_branch      (ex_branch),
        .ex_branch_addr (ex_branch_addr),
        .trap_req       (trap_req),
        .trap_vec       (trap_vec),
        .trap_ack       (trap_ack),
        .pc_hold        (pc_hold),
        .pc_branch      (pc_branch),
        .pc_branch_addr (pc_branch_addr),
        .flush_if       (flush_if),
        .flush_id       (flush_id),
        .pend_valid     (pend_valid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pv = 0; m_prank = 0; m_paddr = '0; m_ack_last = 0;
    endtask

    // Called just after a falling edge: apply inputs, check outputs, advance one clock.
    task automatic step(input bit rdy, input bit stl,
                        input bit idj, input logic [AW-1:0] ida,
                        input bit exb, input logic [AW-1:0] exa,
                        input bit trp, input logic [AW-1:0] vec);
        int            cand_rank, win_rank;
        logic [AW-1:0] cand_addr, win_addr;
        bit            hold, e_br;
        imem_ready = rdy; stall_req = stl;
        id_jump = idj; id_jump_addr = ida;
        ex_branch = exb; ex_branch_addr = exa;
        trap_req = trp; trap_vec = vec;
        #1;
        cand_rank = 0; cand_addr = '0;
        if (idj) begin cand_rank = 1; cand_addr = ida; end
        if (exb) begin cand_rank = 2; cand_addr = exa; end
        if (trp && !m_ack_last) begin cand_rank = 3; cand_addr = vec; end
        if (m_pv && m_prank >= cand_rank) begin
            win_rank = m_prank; win_addr = m_paddr;
        end else begin
            win_rank = cand_rank; win_addr = cand_addr;
        end
        hold = !rdy || stl;
        e_br = !hold && (win_rank != 0);
        chk("pc_hold",    64'(pc_hold),    64'(hold));
        chk("pc_branch",  64'(pc_branch),  64'(e_br));
        chk("pend_valid", 64'(pend_valid), 64'(m_pv));
        chk("flush_if",   64'(flush_if),   64'(e_br));
        chk("flush_id",   64'(flush_id),   64'(e_br && win_rank >= 2));
        chk("trap_ack",   64'(trap_ack),   64'(e_br && win_rank == 3));
        if (e_br) chk("br_addr", 64'(pc_branch_addr), 64'(win_addr));
        $display("cyc=%0d rdy=%0b stl=%0b id=%0b ex=%0b trap=%0b -> hold=%0b br=%0b addr=%h fid=%0b ack=%0b pend=%0b",
                 cyc, rdy, stl, idj, exb, trp, pc_hold, pc_branch, pc_branch_addr,
                 flush_id, trap_ack, pend_valid);
        @(posedge clk);
        cyc++;
        m_ack_last = e_br && (win_rank == 3);
        if (hold) begin
            m_pv = (win_rank != 0); m_prank = win_rank; m_paddr = win_addr;
        end else begin
            m_pv = 0; m_prank = 0; m_paddr = '0;
        end
        @(negedge clk);
    endtask

    task automatic idle_step(input bit rdy);
        step(rdy, 0, 0, '0, 0, '0, 0, '0);
    endtask

    initial begin
        bit            t_hold;
        logic [AW-1:0] t_vec;
        rst = 1'b1;
        imem_ready = 1'b0; stall_req = 1'b0;
        id_jump = 1'b0; ex_branch = 1'b0; trap_req = 1'b0;
        id_jump_addr = '0; ex_branch_addr = '0; trap_vec = '0;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_hold",   64'(pc_hold),    64'd0);
        chk("rst_branch", 64'(pc_branch),  64'd0);
        chk("rst_pend",   64'(pend_valid), 64'd0);
        chk("rst_ack",    64'(trap_ack),   64'd0);
        @(negedge clk);
        rst = 1'b0;

        // ex_branch while running: zero-latency redirect with both flushes
        step(1, 0, 0, '0, 1, 32'h100, 0, '0);
        // id_jump and ex_branch together: branch wins
        step(1, 0, 1, 32'h40, 1, 32'h80, 0, '0);
        // memory not ready three cycles, jump captured then issued on release
        step(0, 0, 1, 32'h20, 0, '0, 0, '0);
        idle_step(0);
        idle_step(0);
        idle_step(1);
        // pending jump overwritten by trap, trap acked on release
        step(0, 0, 1, 32'h20, 0, '0, 0, '0);
        step(0, 0, 0, '0, 0, '0, 1, 32'h8);
        step(1, 0, 0, '0, 0, '0, 1, 32'h8);
        step(1, 0, 0, '0, 0, '0, 1, 32'h8);   // trap still high the cycle after ack
        idle_step(1);
        // pending branch not displaced by a lower-priority jump
        step(1, 1, 0, '0, 1, 32'hA0, 0, '0);
        step(0, 0, 1, 32'h44, 0, '0, 0, '0);
        step(1, 0, 1, 32'h48, 0, '0, 0, '0);
        // reset while pending discards the redirect
        step(0, 0, 1, 32'h60, 0, '0, 0, '0);
        rst = 1'b1;
        #1;
        chk("rstmid_pend",   64'(pend_valid), 64'd0);
        chk("rstmid_branch", 64'(pc_branch),  64'd0);
        chk("rstmid_hold",   64'(pc_hold),    64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_step(1);
        idle_step(1);

        // random traffic; trap held until acknowledged
        t_hold = 0; t_vec = '0;
        for (int i = 0; i < 400; i++) begin
            bit            rdy, stl, idj, exb;
            logic [AW-1:0] ida, exa;
            rdy = ($urandom_range(0, 3) != 0);
            stl = ($urandom_range(0, 4) == 0);
            idj = ($urandom_range(0, 3) == 0);
            exb = ($urandom_range(0, 4) == 0);
            ida = $urandom; exa = $urandom;
            if (!t_hold && $urandom_range(0, 9) == 0) begin
                t_hold = 1; t_vec = $urandom;
            end
            step(rdy, stl, idj, ida, exb, exa, t_hold, t_vec);
            if (m_ack_last) t_hold = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
